// File: rtl/du_tx_arbiter.sv
// du_tx_arbiter: round-robin owner of the debug unit's single UART transmitter.
// The winner's word is copied when it is granted. The word is then sent one byte at a
// time, least significant byte first, using the UART tx_start/tx_done handshake. When the
// last byte is done, the owner gets a one-cycle ack.
module du_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int NB_DATA = 32,
    parameter int N_BITS  = 8,
    parameter int N_BYTES = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*NB_DATA-1:0] i_data,
    input  logic [N_REQ*3-1:0]       i_nbytes,
    input  logic                     i_tx_done,
    output logic [N_BITS-1:0]        o_tx_data,
    output logic                     o_tx_start,
    output logic [N_REQ-1:0]         o_grant,
    output logic [N_REQ-1:0]         o_ack,
    output logic                     o_busy,
    output logic [1:0]               o_state
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [NB_DATA-1:0]  word_q, word_d;
    logic [2:0]          last_q, last_d;
    logic [2:0]          byte_cnt_q, byte_cnt_d;
    logic [N_BITS-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                busy_q, busy_d;

    logic                pick_found;
    logic [PTR_W-1:0]    pick_idx;
    logic [PTR_W-1:0]    cand;
    logic [2:0]          sel_nb;
    logic [2:0]          pick_last;

    // Round-robin pick: the first active request at or after the pointer, wrapping around.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % N_REQ);
            if (!pick_found && i_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Index of the winner's last byte. A count of 0 means 1 byte; counts above N_BYTES are clamped.
    always_comb begin
        sel_nb = i_nbytes[int'(pick_idx)*3 +: 3];
        if (sel_nb == 3'd0)
            pick_last = 3'd0;
        else if (int'(sel_nb) > N_BYTES)
            pick_last = 3'(N_BYTES - 1);
        else
            pick_last = sel_nb - 3'd1;
    end

    // FSM next state. Every output is computed here one cycle early and then registered.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        word_d     = word_q;
        last_d     = last_q;
        byte_cnt_d = byte_cnt_q;
        grant_d    = grant_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    win_d           = pick_idx;
                    word_d          = i_data[int'(pick_idx)*NB_DATA +: NB_DATA];
                    last_d          = pick_last;
                    byte_cnt_d      = 3'd0;
                    grant_d         = '0;
                    grant_d[pick_idx] = 1'b1;
                    tx_start_d      = 1'b1;
                    state_d         = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_tx_done) begin
                    if (byte_cnt_q == last_q) begin
                        ack_d   = grant_q;
                        state_d = S_ACK;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        tx_start_d = 1'b1;
                        state_d    = S_START;
                    end
                end
            end
            S_ACK: begin
                grant_d = '0;
                ptr_d   = PTR_W'((int'(win_q) + 1) % N_REQ);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Load the byte being started. It then stays unchanged through WAIT.
        if (tx_start_d)
            tx_data_d = word_d[int'(byte_cnt_d)*N_BITS +: N_BITS];

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            // NOTE: the snapshot and data registers are reset too, so o_tx_data reads 0 after reset.
            word_q     <= '0;
            last_q     <= '0;
            byte_cnt_q <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            grant_q    <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register updates from pre-edge values.
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            word_q     <= word_d;
            last_q     <= last_d;
            byte_cnt_q <= byte_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_grant    = grant_q;
    assign o_ack      = ack_q;
    assign o_busy     = busy_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_du_tx_arbiter.sv
// Testbench for du_tx_arbiter.
// A behavioural model supplies the expected values: the round-robin winner, the byte count,
// and each byte taken from the word at grant time. A simple UART responder answers every start.
module tb_du_tx_arbiter;

    logic         clk;
    logic         i_reset;
    logic [3:0]   i_req;
    logic [127:0] i_data;
    logic [11:0]  i_nbytes;
    logic         i_tx_done;
    logic [7:0]   o_tx_data;
    logic         o_tx_start;
    logic [3:0]   o_grant;
    logic [3:0]   o_ack;
    logic         o_busy;
    logic [1:0]   o_state;

    int checks   = 0;
    int failures = 0;
    int exp_ptr  = 0;

    du_tx_arbiter #(.N_REQ(4), .NB_DATA(32), .N_BITS(8), .N_BYTES(4)) dut (
        .i_clock    (clk),
        .i_reset    (i_reset),
        .i_req      (i_req),
        .i_data     (i_data),
        .i_nbytes   (i_nbytes),
        .i_tx_done  (i_tx_done),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_grant    (o_grant),
        .o_ack      (o_ack),
        .o_busy     (o_busy),
        .o_state    (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock. Outputs are sampled and inputs changed 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: the first active requester at or after the pointer, wrapping around.
    function automatic int model_pick(input logic [3:0] req, input int ptr);
        for (int i = 0; i < 4; i++)
            if (req[(ptr + i) % 4]) return (ptr + i) % 4;
        return 0;
    endfunction

    function automatic int model_len(input logic [2:0] nb);
        if (nb == 3'd0) return 1;
        if (nb > 3'd4) return 4;
        return int'(nb);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, o_state, 0);
        check({tag, "_grant"}, o_grant, 0);
        check({tag, "_ack"},   o_ack,   0);
        check({tag, "_start"}, o_tx_start, 0);
        check({tag, "_data"},  o_tx_data, 0);
        check({tag, "_busy"},  o_busy, 0);
    endtask

    // Runs one full transfer, starting from IDLE with the requests already driven.
    // force_w >= 0 sets the expected winner directly; otherwise the model predicts it.
    task automatic serve_one(input int force_w, input bit drop_on_ack, input bit mutate,
                             input bit drop_mid, input int abort_at, output bit aborted);
        int          w;
        int          n;
        logic [31:0] word;
        logic [7:0]  exp_byte;
        logic [3:0]  gexp;
        aborted = 1'b0;
        w    = (force_w >= 0) ? force_w : model_pick(i_req, exp_ptr);
        word = i_data[w*32 +: 32];
        n    = model_len(i_nbytes[w*3 +: 3]);
        gexp = 4'(1 << w);
        tick();
        for (int j = 0; j < n; j++) begin
            exp_byte = 8'((word >> (8*j)) & 32'hFF);
            check("start_pulse", o_tx_start, 1);
            check("start_state", o_state, 1);
            check("start_data",  o_tx_data, exp_byte);
            check("start_grant", o_grant, gexp);
            check("start_busy",  o_busy, 1);
            tick();
            check("wait_state",   o_state, 2);
            check("wait_nostart", o_tx_start, 0);
            check("wait_data",    o_tx_data, exp_byte);
            if (mutate && j == 0) i_data[w*32 +: 32] = ~word;
            if (drop_mid && j == 0) i_req[w] = 1'b0;
            if (j == abort_at) begin
                i_reset = 1'b1;
                #1;
                check_all_zero("async_rst");
                aborted = 1'b1;
                return;
            end
            repeat ($urandom_range(0, 3)) begin
                tick();
                check("wait_hold", o_state, 2);
            end
            i_tx_done = 1'b1;
            tick();
            i_tx_done = 1'b0;
        end
        check("ack_pulse", o_ack, gexp);
        check("ack_state", o_state, 3);
        check("ack_grant", o_grant, gexp);
        check("ack_nostart", o_tx_start, 0);
        if (drop_on_ack) i_req[w] = 1'b0;
        exp_ptr = (w + 1) % 4;
        tick();
        check("idle_state", o_state, 0);
        check("idle_grant", o_grant, 0);
        check("idle_ack",   o_ack, 0);
        check("idle_busy",  o_busy, 0);
    endtask

    initial begin
        bit          ab;
        logic [3:0]  extra;
        i_reset   = 1'b1;
        i_req     = '0;
        i_data    = '0;
        i_nbytes  = '0;
        i_tx_done = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        i_reset = 1'b0;
        exp_ptr = 0;
        tick();

        // Simultaneous requests 0 and 2 with the pointer at 0.
        i_data   = {32'h44444444, 32'h000000C2, 32'h22222222, 32'h000000C0};
        i_nbytes = {3'd1, 3'd1, 3'd1, 3'd1};
        i_req    = 4'b0101;
        serve_one(0, 1, 0, 0, -1, ab);
        serve_one(2, 1, 0, 0, -1, ab);
        // All four held high: expected order is 3, 0, 1, 2.
        i_data = {32'h000000D3, 32'h000000D2, 32'h000000D1, 32'h000000D0};
        i_req  = 4'b1111;
        serve_one(3, 0, 0, 0, -1, ab);
        serve_one(0, 0, 0, 0, -1, ab);
        serve_one(1, 0, 0, 0, -1, ab);
        serve_one(2, 0, 0, 0, -1, ab);
        i_req = '0;

        // Single byte from requester 0.
        i_data[31:0]   = 32'h000000A5;
        i_nbytes[2:0]  = 3'd1;
        i_req          = 4'b0001;
        serve_one(0, 1, 0, 0, -1, ab);

        // Four bytes from requester 1, sent LSB first.
        i_data[63:32]  = 32'h11223344;
        i_nbytes[5:3]  = 3'd4;
        i_req          = 4'b0010;
        serve_one(1, 1, 0, 0, -1, ab);

        // Requester 0 changes its data after the grant; the copy taken at grant is what gets sent.
        i_data[31:0]  = 32'hDEADBEEF;
        i_nbytes[2:0] = 3'd4;
        i_req         = 4'b0001;
        serve_one(0, 1, 1, 0, -1, ab);

        // A count of 0 sends 1 byte; a count of 7 sends 4 bytes; a done pulse in IDLE is ignored.
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("idle_done_state", o_state, 0);
        check("idle_done_busy",  o_busy, 0);
        check("idle_done_start", o_tx_start, 0);
        i_data[95:64]   = 32'h5566778A;
        i_nbytes[8:6]   = 3'd0;
        i_req           = 4'b0100;
        serve_one(2, 1, 0, 0, -1, ab);
        i_data[127:96]  = 32'hCAFEF00D;
        i_nbytes[11:9]  = 3'd7;
        i_req           = 4'b1000;
        serve_one(3, 1, 0, 0, -1, ab);

        // Reset during WAIT after 2 of 4 bytes. Once reset is released the pointer is back at 0.
        i_data[95:64]  = 32'h000000E2;
        i_nbytes[8:6]  = 3'd1;
        i_req          = 4'b0100;
        serve_one(2, 1, 0, 0, -1, ab);
        i_data[31:0]   = 32'h0A0B0C0D;
        i_nbytes[2:0]  = 3'd2;
        i_data[127:96] = 32'h9A8B7C6D;
        i_nbytes[11:9] = 3'd4;
        i_req          = 4'b1001;
        serve_one(3, 1, 0, 0, 2, ab);
        check("abort_taken", ab, 1);
        tick();
        check_all_zero("rst_hold");
        i_reset = 1'b0;
        exp_ptr = 0;
        serve_one(0, 1, 0, 0, -1, ab);
        serve_one(3, 1, 0, 0, -1, ab);

        // Random requests, data and byte counts, checked against the model.
        for (int it = 0; it < 40; it++) begin
            extra = 4'($urandom_range(0, 15)) & ~i_req;
            if (i_req == 4'b0000 && extra == 4'b0000) extra = 4'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++) begin
                if (extra[k]) begin
                    i_data[k*32 +: 32]  = $urandom;
                    i_nbytes[k*3 +: 3]  = 3'($urandom_range(0, 7));
                end
            end
            i_req = i_req | extra;
            serve_one(-1, 1, 0, ($urandom_range(0, 3) == 0), -1, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
